// File: rtl/rst_seq_pkg.sv
// Package for the reset sequencer.
// Holds the FSM state encoding, the parameter legality limit and the helper
// that sizes the shared hold/gap counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_GAP  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int MAX_STAGES = 8;

  // The counter must reach max(hold, gap) - 1. It is never narrower than one
  // bit, so the hold=gap=1 corner still gets a real register.
  function automatic int cnt_width(input int hold_cycles, input int stage_gap);
    int m;
    int w;
    m = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable up-counter shared by the HOLD and GAP phases of rst_sequencer.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clear       return the count to zero on the next edge (wins over enable)
//   enable      advance the count by one on the next edge
//   term        terminal value for the current phase
//   tc          high while the count equals term
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: after the system reset falls, holds every downstream reset
// domain for HOLD_CYCLES, then releases them one by one (bit 0 first) every
// STAGE_GAP cycles, and raises ready STAGE_GAP cycles after the last release.
// soft_rst_req reruns the whole sequence without a board-level reset.
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset, dominates everything
//   soft_rst_req  one-cycle request to restart the sequence
//   stage_ack     per-stage release acknowledge (only with RST_SEQ_ACK_EN)
//   stage_rst     active-high stage resets, bit 0 released first
//   ready         high once every stage is released
//   busy          high while the sequence runs (inverse of ready)
// Build option:
//   RST_SEQ_ACK_EN  adds stage_ack; each gap waits for the current stage's ack
//                   before advancing.
// Handshake: stage_ack is a level, not a valid/ready pair. stage_ack[idx] is
// sampled only when the gap counter is at its terminal value; while it is low
// the counter sits at STAGE_GAP-1, so an ack already high costs no extra cycle.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_rst_req,
`ifdef RST_SEQ_ACK_EN
  input  logic [NUM_STAGES-1:0] stage_ack,
`endif
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("rst_sequencer: NUM_STAGES=%0d outside 1..%0d", NUM_STAGES, MAX_STAGES);
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_sequencer: HOLD_CYCLES=%0d must be >= 1", HOLD_CYCLES);
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("rst_sequencer: STAGE_GAP=%0d must be >= 1", STAGE_GAP);
  end

  seq_state_t            state, state_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [NUM_STAGES-1:0] stage_rst_nx;
  logic                  ready_nx;
  logic                  busy_nx;
  logic                  tmr_clear;
  logic                  tmr_en;
  logic [CNT_W-1:0]      tmr_term;
  logic                  tmr_tc;
  logic                  ack_ok;

  rst_seq_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .term   (tmr_term),
    .tc     (tmr_tc)
  );

`ifdef RST_SEQ_ACK_EN
  // Ack of the stage most recently released; idx never exceeds LAST_IDX.
  always_comb begin
    ack_ok = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i == int'(idx)) ack_ok = stage_ack[i];
    end
  end
`else
  assign ack_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HOLD;
      idx       <= '0;
      stage_rst <= '1;
      ready     <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      stage_rst <= stage_rst_nx;
      ready     <= ready_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    stage_rst_nx = stage_rst;
    ready_nx     = ready;
    busy_nx      = busy;
    tmr_clear    = 1'b0;
    tmr_en       = 1'b0;
    tmr_term     = HOLD_TC;

    if (soft_rst_req) begin
      // Same landing point as reset; a held request keeps the count at zero.
      state_nx     = ST_HOLD;
      idx_nx       = '0;
      stage_rst_nx = '1;
      ready_nx     = 1'b0;
      busy_nx      = 1'b1;
      tmr_clear    = 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          tmr_term = HOLD_TC;
          tmr_en   = 1'b1;
          if (tmr_tc) begin
            stage_rst_nx[0] = 1'b0;
            tmr_clear       = 1'b1;
            state_nx        = ST_GAP;
          end
        end
        ST_GAP: begin
          tmr_term = GAP_TC;
          if (!tmr_tc) begin
            tmr_en = 1'b1;
          end else if (ack_ok) begin
            tmr_clear = 1'b1;
            if (idx != LAST_IDX) begin
              for (int i = 1; i < NUM_STAGES; i++) begin
                if (i == int'(idx) + 1) stage_rst_nx[i] = 1'b0;
              end
              idx_nx = idx + 1'b1;
            end else begin
              state_nx = ST_DONE;
              ready_nx = 1'b1;
              busy_nx  = 1'b0;
            end
          end
          // tc with no ack: counter parks at STAGE_GAP-1 until the ack shows up.
        end
        ST_DONE: begin
          tmr_term = GAP_TC;
        end
        default: begin
          state_nx = ST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: a default-parameter instance and a 1/1/1 instance
// share reset and soft_rst_req. The reference model counts edges since the
// last edge that saw reset or a soft request, and derives every output from
// the release-time arithmetic H + i*G (stages) and H + N*G (ready).
module tb_rst_sequencer;

  localparam int N  = 3;
  localparam int H  = 16;
  localparam int G  = 4;
  localparam int N2 = 1;
  localparam int H2 = 1;
  localparam int G2 = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          soft_rst_req;
  logic [N-1:0]  stage_rst;
  logic          ready;
  logic          busy;
  logic [N2-1:0] stage_rst2;
  logic          ready2;
  logic          busy2;
`ifdef RST_SEQ_ACK_EN
  logic [N-1:0]  stage_ack;
  logic [N2-1:0] stage_ack2;
`endif

  int checks;
  int errors;
  int e;  // edges since the last edge with reset or soft_rst_req high

  always #5 clk = ~clk;

  rst_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(H), .STAGE_GAP(G)) dut (
    .clk          (clk),
    .reset        (reset),
    .soft_rst_req (soft_rst_req),
`ifdef RST_SEQ_ACK_EN
    .stage_ack    (stage_ack),
`endif
    .stage_rst    (stage_rst),
    .ready        (ready),
    .busy         (busy)
  );

  rst_sequencer #(.NUM_STAGES(N2), .HOLD_CYCLES(H2), .STAGE_GAP(G2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .soft_rst_req (soft_rst_req),
`ifdef RST_SEQ_ACK_EN
    .stage_ack    (stage_ack2),
`endif
    .stage_rst    (stage_rst2),
    .ready        (ready2),
    .busy         (busy2)
  );

  // Expected {stage_rst, ready, busy} for a block with n stages, e edges in.
  function automatic logic [9:0] model(input int ed, input int n, input int h, input int g);
    logic [7:0] r;
    logic       rdy;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = (ed < h + i * g);
    rdy = (ed >= h + n * g);
    return {r, rdy, ~rdy};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset || soft_rst_req) e = 0;
    else if (e < 100000) e++;
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] m;
    reset = 1'b1; soft_rst_req = 1'b0;
    repeat (3) tick();
    checks++;
    if ({stage_rst, ready, busy} !== 5'b111_0_1) begin
      errors++;
      $display("FAIL reset_state got %b want %b", {stage_rst, ready, busy}, 5'b111_0_1);
    end
    reset = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      m = model(e, N, H, G);
      checks++;
      if ({stage_rst, ready, busy} !== {m[N+1:2], m[1:0]}) begin
        errors++;
        $display("FAIL seq_edge%0d got %b want %b", n, {stage_rst, ready, busy}, {m[N+1:2], m[1:0]});
      end
      if (n == 16 || n == 20 || n == 24 || n == 28) begin
        checks++;
        if (stage_rst !== ((n == 16) ? 3'b110 : (n == 20) ? 3'b100 : 3'b000) ||
            ready !== (n == 28)) begin
          errors++;
          $display("FAIL spot_edge%0d got rst=%b rdy=%b", n, stage_rst, ready);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] m;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int n = 1; n <= 21; n++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (stage_rst !== 3'b111 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got rst=%b rdy=%b want 111/0", stage_rst, ready);
    end
    reset = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      m = model(e, N, H, G);
      checks++;
      if ({stage_rst, ready, busy} !== {m[N+1:2], m[1:0]}) begin
        errors++;
        $display("FAIL rerun_edge%0d got %b want %b", n, {stage_rst, ready, busy}, {m[N+1:2], m[1:0]});
      end
    end
  endtask

  task automatic test_soft_done();
    logic [9:0] m;
    repeat (10) tick();  // now deep in DONE
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    checks++;
    if ({stage_rst, ready, busy} !== 5'b111_0_1) begin
      errors++;
      $display("FAIL soft_done got %b want %b", {stage_rst, ready, busy}, 5'b111_0_1);
    end
    for (int n = 1; n <= 30; n++) begin
      tick();
      m = model(e, N, H, G);
      checks++;
      if ({stage_rst, ready, busy} !== {m[N+1:2], m[1:0]}) begin
        errors++;
        $display("FAIL soft_edge%0d got %b want %b", n, {stage_rst, ready, busy}, {m[N+1:2], m[1:0]});
      end
    end
  endtask

  task automatic test_soft_with_reset();
    logic [9:0] m;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int n = 1; n <= 17; n++) tick();
    reset = 1'b1; soft_rst_req = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();  // request still held: must stay in hold with count at zero
    soft_rst_req = 1'b0;
    checks++;
    if ({stage_rst, ready, busy} !== 5'b111_0_1) begin
      errors++;
      $display("FAIL both_held got %b want %b", {stage_rst, ready, busy}, 5'b111_0_1);
    end
    for (int n = 1; n <= 30; n++) begin
      tick();
      m = model(e, N, H, G);
      checks++;
      if ({stage_rst, ready, busy} !== {m[N+1:2], m[1:0]}) begin
        errors++;
        $display("FAIL both_edge%0d got %b want %b", n, {stage_rst, ready, busy}, {m[N+1:2], m[1:0]});
      end
    end
  endtask

  task automatic test_min_config();
    reset = 1'b1; tick();
    checks++;
    if ({stage_rst2, ready2, busy2} !== 3'b1_0_1) begin
      errors++;
      $display("FAIL min_reset got %b want 101", {stage_rst2, ready2, busy2});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({stage_rst2, ready2, busy2} !== 3'b0_0_1) begin
      errors++;
      $display("FAIL min_edge1 got %b want 001", {stage_rst2, ready2, busy2});
    end
    tick();
    checks++;
    if ({stage_rst2, ready2, busy2} !== 3'b0_1_0) begin
      errors++;
      $display("FAIL min_edge2 got %b want 010", {stage_rst2, ready2, busy2});
    end
  endtask

  task automatic test_random();
    logic [9:0] m;
    logic [9:0] m2;
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 63) == 0);
      soft_rst_req = ($urandom_range(0, 31) == 0);
      tick();
      m  = model(e, N, H, G);
      m2 = model(e, N2, H2, G2);
      checks++;
      if ({stage_rst, ready, busy} !== {m[N+1:2], m[1:0]}) begin
        errors++;
        $display("FAIL rand_main c=%0d e=%0d got %b want %b", c, e, {stage_rst, ready, busy}, {m[N+1:2], m[1:0]});
      end
      checks++;
      if ({stage_rst2, ready2, busy2} !== {m2[N2+1:2], m2[1:0]}) begin
        errors++;
        $display("FAIL rand_min c=%0d e=%0d got %b want %b", c, e, {stage_rst2, ready2, busy2}, {m2[N2+1:2], m2[1:0]});
      end
    end
    reset = 1'b0; soft_rst_req = 1'b0;
  endtask

`ifdef RST_SEQ_ACK_EN
  task automatic test_ack();
    logic [N-1:0] exp_rst;
    logic         exp_rdy;
    stage_ack = 3'b110;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      tick();
      if (n == 30) stage_ack = 3'b111;  // first sampled at edge 31
      exp_rst = (n < 16) ? 3'b111 : (n < 31) ? 3'b110 : (n < 35) ? 3'b100 : 3'b000;
      exp_rdy = (n >= 39);
      checks++;
      if ({stage_rst, ready, busy} !== {exp_rst, exp_rdy, ~exp_rdy}) begin
        errors++;
        $display("FAIL ack_edge%0d got %b want %b", n, {stage_rst, ready, busy}, {exp_rst, exp_rdy, ~exp_rdy});
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    e = 0;
    reset = 1'b1;
    soft_rst_req = 1'b0;
`ifdef RST_SEQ_ACK_EN
    stage_ack  = '1;
    stage_ack2 = '1;
`endif
    test_reset();
    test_reset_mid();
    test_soft_done();
    test_soft_with_reset();
    test_min_config();
    test_random();
`ifdef RST_SEQ_ACK_EN
    test_ack();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
